mem_io_responder: RTL and testbench

- Responder side of the CPU data-memory bus.
- Services the core's MemR/MemW requests and returns read data on readBus.
- Contains a word-addressed data RAM plus memory-mapped I/O: a 4-bit input port (inr) and a 16-bit output latch (outvalue).
- Inserts a configurable number of wait states, so the core stalls on a ready handshake.

---
 rtl/mem_io_responder_pkg.sv | 31 +++
 rtl/mem_io_ram.sv | 25 ++
 rtl/mem_io_responder.sv | 148 ++++++++++++++
 tb/tb_mem_io_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared address map, FSM encoding and address decode for mem_io_responder.
package mem_io_responder_pkg;

    localparam logic [15:0] ADDR_INPORT  = 16'hFFF0;
    localparam logic [15:0] ADDR_OUTPORT = 16'hFFF1;
    localparam logic [15:0] ADDR_STATUS  = 16'hFFF2;
    localparam logic [15:0] RAM_TOP      = 16'hFEFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_INPORT,
        RGN_OUTPORT,
        RGN_STATUS,
        RGN_NONE
    } region_t;

    function automatic region_t decode_region(input logic [15:0] a);
        if (a <= RAM_TOP)           return RGN_RAM;
        else if (a == ADDR_INPORT)  return RGN_INPORT;
        else if (a == ADDR_OUTPORT) return RGN_OUTPORT;
        else if (a == ADDR_STATUS)  return RGN_STATUS;
        else                        return RGN_NONE;
    endfunction

endpackage

// File: rtl/mem_io_ram.sv
// Single-port data RAM with write enable and a registered, enable-gated read port.
module mem_io_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // The read register only moves on i_re, so it holds the last read word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_io_responder.sv
// Data-memory bus responder: RAM plus memory-mapped I/O with wait states.
// Define MEM_IO_BUS_ERR_EN to add the sticky bus_err output.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemR,
    input  logic              MemW,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [3:0]        inr,
    output logic [DATA_W-1:0] readBus,
    output logic              ready,
    output logic [DATA_W-1:0] outvalue,
`ifdef MEM_IO_BUS_ERR_EN
    output logic              bus_err,
`endif
    output logic [1:0]        o_dbg_state
);

    // Handshake: MemR/MemW are held until ready; ready pulses for one cycle,
    // a read's data is on readBus in that cycle, and a new request is taken only from IDLE.
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            r_state;
    logic [15:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_op_wr;
    logic [3:0]        r_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd_ram;
    logic [DATA_W-1:0] r_outvalue;
    logic [3:0]        r_inr;

    logic              w_req;
    logic              w_enter_resp;
    logic              w_op_wr_next;
    logic [15:0]       w_addr_cur;
    region_t           w_rgn_cur;
    region_t           w_rgn_lat;
    logic              w_ram_re;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_io_rdata;

    assign w_req        = MemR | MemW;
    assign w_op_wr_next = (r_state == IDLE) ? MemW : r_op_wr;
    assign w_addr_cur   = (r_state == IDLE) ? addr : r_addr;
    assign w_rgn_cur    = decode_region(w_addr_cur);
    assign w_rgn_lat    = decode_region(r_addr);
    assign w_enter_resp = ((r_state == IDLE) && w_req && (WS == 4'd0)) ||
                          ((r_state == WAIT) && w_req && (r_cnt == WS));

    // RAM read fires on the edge entering RESP; the write commits on the edge leaving it.
    assign w_ram_re = w_enter_resp && !w_op_wr_next && (w_rgn_cur == RGN_RAM);
    assign w_ram_we = !reset && (r_state == RESP) && r_op_wr && (w_rgn_lat == RGN_RAM);

    mem_io_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_addr_cur[ADDR_W-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_io_rdata = '0;
        case (w_rgn_cur)
            RGN_INPORT:  w_io_rdata = DATA_W'(r_inr);
            RGN_OUTPORT: w_io_rdata = r_outvalue;
            RGN_STATUS:  w_io_rdata = DATA_W'(WAIT_STATES);
            default:     w_io_rdata = '0;
        endcase
    end

`ifdef MEM_IO_BUS_ERR_EN
    logic r_bus_err;
    logic w_bad_access;
    assign w_bad_access = (w_rgn_lat == RGN_NONE) ||
                          (r_op_wr && ((w_rgn_lat == RGN_INPORT) || (w_rgn_lat == RGN_STATUS)));
    assign bus_err = r_bus_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_op_wr    <= 1'b0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_rd_ram   <= 1'b0;
            r_outvalue <= '0;
            r_inr      <= '0;
`ifdef MEM_IO_BUS_ERR_EN
            r_bus_err  <= 1'b0;
`endif
        end else begin
            r_inr   <= inr;
            r_ready <= w_enter_resp;
            if (w_enter_resp && !w_op_wr_next) begin
                r_rd_ram <= (w_rgn_cur == RGN_RAM);
                r_rdata  <= w_io_rdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_wdata <= WriteData;
                        r_op_wr <= MemW;
                        r_cnt   <= 4'd1;
                        r_state <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!w_req)          r_state <= IDLE;
                    else if (r_cnt == WS) r_state <= RESP;
                    else                  r_cnt   <= r_cnt + 4'd1;
                end
                RESP: begin
                    if (r_op_wr && (w_rgn_lat == RGN_OUTPORT)) r_outvalue <= r_wdata;
`ifdef MEM_IO_BUS_ERR_EN
                    if (w_bad_access) r_bus_err <= 1'b1;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign readBus     = r_rd_ram ? w_ram_q : r_rdata;
    assign ready       = r_ready;
    assign outvalue    = r_outvalue;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized scoreboard bench for mem_io_responder against an address-map model.
// Build with MEM_IO_BUS_ERR_EN defined to also check bus_err.
module tb_mem_io_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int WS     = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              MemR;
    logic              MemW;
    logic [15:0]       addr;
    logic [DATA_W-1:0] WriteData;
    logic [3:0]        inr;
    logic [DATA_W-1:0] readBus;
    logic              ready;
    logic [DATA_W-1:0] outvalue;
    logic [1:0]        dbg_state;
`ifdef MEM_IO_BUS_ERR_EN
    logic              bus_err;
`endif

    mem_io_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemR        (MemR),
        .MemW        (MemW),
        .addr        (addr),
        .WriteData   (WriteData),
        .inr         (inr),
        .readBus     (readBus),
        .ready       (ready),
        .outvalue    (outvalue),
`ifdef MEM_IO_BUS_ERR_EN
        .bus_err     (bus_err),
`endif
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mem_model [256];
    bit                written   [256];
    logic [DATA_W-1:0] out_model;
    logic [3:0]        inr_val;
    bit                err_model;

    int n_vec  = 0;
    int n_fail = 0;
    logic [DATA_W:0] exp_q [$];

    function automatic logic [DATA_W-1:0] model_read(input logic [15:0] a);
        if (a <= 16'hFEFF) return mem_model[a[7:0]];
        case (a)
            16'hFFF0: return {12'd0, inr_val};
            16'hFFF1: return out_model;
            16'hFFF2: return DATA_W'(WS);
            default:  return '0;
        endcase
    endfunction

    function automatic bit model_err(input logic [15:0] a, input logic wr);
        bit unmapped;
        unmapped = (a > 16'hFEFF) && (a != 16'hFFF0) && (a != 16'hFFF1) && (a != 16'hFFF2);
        return unmapped || (wr && ((a == 16'hFFF0) || (a == 16'hFFF2)));
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [DATA_W-1:0] d);
        if (a <= 16'hFEFF) begin
            mem_model[a[7:0]] = d;
            written[a[7:0]]   = 1'b1;
        end else if (a == 16'hFFF1) begin
            out_model = d;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [DATA_W:0] e;
        if (!reset && ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 32'(ready), 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e[DATA_W]) check("readBus", 32'(readBus), 32'(e[DATA_W-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [DATA_W-1:0] d);
        int lat = 0;
        bit seen = 1'b0;
        if (wr) begin
            model_write(a, d);
            exp_q.push_back({1'b0, d});
        end else begin
            exp_q.push_back({1'b1, model_read(a)});
        end
        if (model_err(a, wr)) err_model = 1'b1;
        @(posedge clk); #1;
        MemR = rd; MemW = wr; addr = a; WriteData = d;
        @(posedge clk); #1;
        // Operands change after accept; the DUT must keep using the latched ones.
        addr = 16'($urandom);
        WriteData = DATA_W'($urandom);
        while (lat < 20 && !seen) begin
            @(negedge clk);
            lat++;
            seen = ready;
        end
        MemR = 1'b0; MemW = 1'b0;
        if (!seen) void'(exp_q.pop_back());
        check("latency", seen ? 32'(lat) : 32'd0, 32'(WS + 1));
        @(negedge clk);
        check("outvalue", 32'(outvalue), 32'(out_model));
`ifdef MEM_IO_BUS_ERR_EN
        check("bus_err", 32'(bus_err), 32'(err_model));
`endif
    endtask

    task automatic start_unchecked(input logic wr, input logic [15:0] a,
                                   input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        MemR = !wr; MemW = wr; addr = a; WriteData = d;
        @(posedge clk); #1;
    endtask

    task automatic set_inr(input logic [3:0] v);
        inr_val = v;
        inr = v;
        repeat (2) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] a;
        logic [7:0]  idx;
        bit          saw_ready;
        int          kind;

        reset = 1'b1; MemR = 1'b0; MemW = 1'b0; addr = '0; WriteData = '0; inr = '0;
        inr_val = '0; out_model = '0; err_model = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = '0;
            written[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_readBus", 32'(readBus), 32'd0);
        check("reset_outvalue", 32'(outvalue), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        // RAM write then read
        issue(1'b0, 1'b1, 16'h0005, 16'h1234);
        issue(1'b1, 1'b0, 16'h0005, 16'h0000);
        // output port write and readback
        issue(1'b0, 1'b1, 16'hFFF1, 16'h00AB);
        issue(1'b1, 1'b0, 16'hFFF1, 16'h0000);
        // input port and status register
        set_inr(4'b0110);
        issue(1'b1, 1'b0, 16'hFFF0, 16'h0000);
        issue(1'b1, 1'b0, 16'hFFF2, 16'h0000);

        // abort: write dropped during WAIT leaves old RAM contents
        issue(1'b0, 1'b1, 16'h0007, 16'h1111);
        start_unchecked(1'b1, 16'h0007, 16'hBEEF);
        MemW = 1'b0;
        saw_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        check("abort_no_ready", 32'(saw_ready), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        issue(1'b1, 1'b0, 16'h0007, 16'h0000);

        // MemR and MemW together is a write
        issue(1'b1, 1'b1, 16'h0008, 16'hC0DE);
        issue(1'b1, 1'b0, 16'h0008, 16'h0000);

        // write to the read-only input port
        issue(1'b0, 1'b1, 16'hFFF0, 16'h5555);
        issue(1'b1, 1'b0, 16'h0005, 16'h0000);

        // reset during WAIT of an output-port write
        start_unchecked(1'b1, 16'hFFF1, 16'h5A5A);
        reset = 1'b1; MemW = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        out_model = '0;
        err_model = 1'b0;
        @(negedge clk);
        check("rst_mid_outvalue", 32'(outvalue), 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
`ifdef MEM_IO_BUS_ERR_EN
        check("rst_mid_bus_err", 32'(bus_err), 32'd0);
`endif
        issue(1'b1, 1'b0, 16'hFFF1, 16'h0000);
        issue(1'b1, 1'b0, 16'h0008, 16'h0000);

        // randomized traffic across the whole address map
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0: issue(1'b0, 1'b1, {8'($urandom_range(0, 254)), 8'($urandom)}, 16'($urandom));
                1: begin
                    idx = 8'($urandom_range(0, 255));
                    while (!written[idx]) idx = idx + 8'd1;
                    issue(1'b1, 1'b0, {8'($urandom_range(0, 254)), idx}, 16'h0000);
                end
                2: issue(1'b0, 1'b1, 16'hFFF1, 16'($urandom));
                3: issue(1'b1, 1'b0, 16'hFFF1, 16'h0000);
                4: begin
                    set_inr(4'($urandom));
                    issue(1'b1, 1'b0, 16'hFFF0, 16'h0000);
                end
                5: issue(1'b1, 1'b0, 16'hFFF2, 16'h0000);
                6: begin
                    a = ($urandom_range(0, 1) == 0) ? 16'hFF00 + 16'($urandom_range(0, 239))
                                                    : 16'hFFF3 + 16'($urandom_range(0, 12));
                    issue(1'b1, 1'b0, a, 16'h0000);
                end
                default: begin
                    a = ($urandom_range(0, 1) == 0) ? 16'hFFF2 : 16'hFF00 + 16'($urandom_range(0, 239));
                    issue(1'b0, 1'b1, a, 16'($urandom));
                end
            endcase
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
